// File: rtl/spi_tx.sv
// SPI mode-0 transmitter: D_W-bit word in over valid/ready, streamed out on cs_n/sclk/mosi.
// Define SPI_TX_LSB_FIRST_EN to send LSB first; default build sends MSB first.
module spi_tx #(
  parameter int D_W     = 8,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [D_W-1:0] tx_data,
  input  logic           tx_valid,
  output logic           tx_ready,
  output logic           sclk,
  output logic           mosi,
  output logic           cs_n,
  output logic           busy,
  output logic           done
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(D_W);
  localparam int GAP_W = $clog2(CS_GAP + 1);

  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_ZERO = BIT_W'(0);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(D_W - 1);
  localparam logic [GAP_W-1:0] GAP_ZERO = GAP_W'(0);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
  localparam logic [D_W-1:0]   SH_ZERO  = D_W'(0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t           state_r,   state_s;
  logic [DIV_W-1:0] div_cnt_r, div_cnt_s;
  logic [GAP_W-1:0] gap_cnt_r, gap_cnt_s;
  logic [BIT_W-1:0] bit_cnt_r, bit_cnt_s;
  logic [D_W-1:0]   shreg_r,   shreg_s;
  logic             sclk_r,    sclk_s;
  logic             mosi_r,    mosi_s;
  logic             cs_n_r,    cs_n_s;
  logic             busy_r,    busy_s;
  logic             done_r,    done_s;

  logic accept_s;
  logic div_end_s;
  logic gap_end_s;
  logic first_bit_s;
  logic next_bit_s;
  logic [D_W-1:0] shifted_s;

  assign accept_s  = tx_valid && (state_r == IDLE);
  assign div_end_s = (div_cnt_r == DIV_LAST);
  assign gap_end_s = (gap_cnt_r == GAP_LAST);

`ifdef SPI_TX_LSB_FIRST_EN
  assign first_bit_s = tx_data[0];
  assign next_bit_s  = shreg_r[1];
  assign shifted_s   = {1'b0, shreg_r[D_W-1:1]};
`else
  assign first_bit_s = tx_data[D_W-1];
  assign next_bit_s  = shreg_r[D_W-2];
  assign shifted_s   = {shreg_r[D_W-2:0], 1'b0};
`endif

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      div_cnt_r <= DIV_ZERO;
      gap_cnt_r <= GAP_ZERO;
      bit_cnt_r <= BIT_ZERO;
      shreg_r   <= SH_ZERO;
      sclk_r    <= 1'b0;
      mosi_r    <= 1'b0;
      cs_n_r    <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      div_cnt_r <= div_cnt_s;
      gap_cnt_r <= gap_cnt_s;
      bit_cnt_r <= bit_cnt_s;
      shreg_r   <= shreg_s;
      sclk_r    <= sclk_s;
      mosi_r    <= mosi_s;
      cs_n_r    <= cs_n_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = LOW;
        else          state_s = IDLE;
      end
      LOW: begin
        if (div_end_s) state_s = HIGH;
        else           state_s = LOW;
      end
      HIGH: begin
        if (div_end_s && (bit_cnt_r == BIT_ZERO)) state_s = GAP;
        else if (div_end_s)                       state_s = LOW;
        else                                      state_s = HIGH;
      end
      GAP: begin
        if (gap_end_s) state_s = IDLE;
        else           state_s = GAP;
      end
      default: state_s = IDLE;
    endcase
  end

  // Next values of counters, shifter and registered pin outputs.
  always_comb begin
    div_cnt_s = div_cnt_r;
    gap_cnt_s = gap_cnt_r;
    bit_cnt_s = bit_cnt_r;
    shreg_s   = shreg_r;
    sclk_s    = sclk_r;
    mosi_s    = mosi_r;
    cs_n_s    = cs_n_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          shreg_s   = tx_data;
          mosi_s    = first_bit_s;
          cs_n_s    = 1'b0;
          sclk_s    = 1'b0;
          busy_s    = 1'b1;
          bit_cnt_s = BIT_LAST;
          div_cnt_s = DIV_ZERO;
        end else begin
          busy_s = 1'b0;
        end
      end
      LOW: begin
        if (div_end_s) begin
          sclk_s    = 1'b1;
          div_cnt_s = DIV_ZERO;
        end else begin
          div_cnt_s = div_cnt_r + DIV_ONE;
        end
      end
      HIGH: begin
        if (div_end_s) begin
          div_cnt_s = DIV_ZERO;
          sclk_s    = 1'b0;
          if (bit_cnt_r != BIT_ZERO) begin
            // mosi moves only together with the sclk falling edge
            shreg_s   = shifted_s;
            mosi_s    = next_bit_s;
            bit_cnt_s = bit_cnt_r - BIT_ONE;
          end else begin
            cs_n_s    = 1'b1;
            mosi_s    = 1'b0;
            done_s    = 1'b1;
            gap_cnt_s = GAP_ZERO;
          end
        end else begin
          div_cnt_s = div_cnt_r + DIV_ONE;
        end
      end
      GAP: begin
        if (gap_end_s) begin
          busy_s    = 1'b0;
          gap_cnt_s = GAP_ZERO;
        end else begin
          gap_cnt_s = gap_cnt_r + GAP_ONE;
        end
      end
      default: begin
        cs_n_s = 1'b1;
        sclk_s = 1'b0;
        mosi_s = 1'b0;
        busy_s = 1'b0;
      end
    endcase
  end

  assign tx_ready = (state_r == IDLE);
  assign sclk     = sclk_r;
  assign mosi     = mosi_r;
  assign cs_n     = cs_n_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: doc/spi_tx.md
Name: spi_tx

Overview:
Parallel-to-serial SPI transmitter (mode 0, CPOL=0/CPHA=0). It accepts a D_W-bit word over a valid/ready handshake and drives cs_n, sclk and mosi to stream the word out. It sits upstream of the DAC-side serial receiver and feeds it words from the sample/control logic. It runs in the clk domain, with sclk derived from clk through a programmable divider.

Parameters:
D_W, 8, word width in bits (>=2)
CLK_DIV, 4, clk cycles per sclk half-period (>=1)
CS_GAP, 2, clk cycles cs_n is held high after a frame before the next frame may be accepted (>=1)

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
tx_data  input  D_W  word to send; sampled only on handshake
tx_valid  input  1  upstream word available
tx_ready  output  1  block can accept a word; high only in IDLE
sclk  output  1  serial clock; idles low
mosi  output  1  serial data; stable across every sclk rising edge
cs_n  output  1  chip select, active-low; low for the whole frame
busy  output  1  high from the cycle after acceptance until return to IDLE
done  output  1  1-cycle pulse at end of frame

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE. sclk=0, mosi=0, cs_n=1, busy=0, done=0, tx_ready=1. Divider counter, bit counter and shift register are cleared.
- Reset mid-frame aborts immediately. cs_n=1 and sclk=0 on the next edge; the partial word is discarded and done is not pulsed.
- All outputs are registered, except tx_ready, which is decoded from the state register (state==IDLE).
- Handshake: a transfer is accepted when tx_valid && tx_ready at a clk edge. tx_data is latched into the shift register on that edge. tx_valid outside IDLE is ignored and must be held by upstream.
- States: IDLE, LOW, HIGH, GAP.
  - IDLE -> LOW on accept. cs_n=0, sclk=0, mosi=tx_data[D_W-1], busy=1, bit_cnt=D_W-1, div_cnt=0.
  - LOW: sclk=0 for CLK_DIV cycles, then -> HIGH with sclk=1.
  - HIGH: sclk=1 for CLK_DIV cycles. At the end of HIGH:
    - if bit_cnt!=0: shift left, mosi=next bit, bit_cnt-1, sclk=0, -> LOW;
    - if bit_cnt==0: sclk=0, cs_n=1, mosi=0, done=1 for one cycle, -> GAP.
  - GAP: cs_n=1 for CS_GAP cycles, then -> IDLE with busy=0.
- Bit order is MSB first. mosi changes only together with an sclk falling edge or on cs_n assertion, so the receiver samples on the sclk rising edge.
- Timing:
  - cs_n low for exactly 2*CLK_DIV*D_W cycles.
  - sclk shows exactly D_W rising edges per frame.
  - First sclk rising edge comes CLK_DIV cycles after cs_n falls.
  - cs_n rises in the same cycle as done.
- Back-to-back: with tx_valid held high, the next word is accepted in the first IDLE cycle. cs_n stays high for CS_GAP+1 cycles between frames.
- Widths: div_cnt is $clog2(CLK_DIV+1) bits; bit_cnt is $clog2(D_W) bits. No counter wrap occurs within a frame.
- CLK_DIV=1: sclk toggles every clk cycle, giving an sclk period of 2 clk cycles. The same rules apply.

Optional Feature:
SPI_TX_LSB_FIRST_EN
- Defined: the word is sent LSB first. On accept, mosi=tx_data[0] and the register shifts right.
- Undefined: MSB first, as above.
- Framing and timing are identical in both cases.

Test Plan:
- D_W=8, CLK_DIV=2, send 0xA5 -> bits sampled on sclk rising edges are 1,0,1,0,0,1,0,1. cs_n low exactly 32 cycles; 8 sclk rises; done pulses once, coincident with cs_n rise.
- Back-to-back 0x3C then 0xFF, tx_valid held high, CS_GAP=2 -> second word accepted in the first IDLE cycle. cs_n high exactly 3 cycles between frames; both words received intact.
- Assert tx_valid with 0x12 while busy with 0x80 -> 0x80 frame is undisturbed; 0x12 is accepted only after GAP and transmitted intact.
- rst_n low for 1 cycle after 3 sclk rises of 0xC3 -> next edge gives cs_n=1, sclk=0, mosi=0, tx_ready=1, no done pulse. A subsequent 0x5A is sent correctly.
- CLK_DIV=1, send 0x01 -> sclk period 2 cycles; cs_n low 16 cycles; bit 1 appears only on the 8th rising edge.
- SPI_TX_LSB_FIRST_EN defined, send 0x01 -> first sampled bit is 1 and the remaining 7 bits are 0; timing is unchanged.
